// File: rtl/multiclickreg_pkg.sv
// multiclickreg_pkg -- shared constants and helpers for the multiclickreg block.
//
// Event word layout (width = 1 + NCH + TW):
//   [roll_bit]              rollover marker
//   [mask_lsb +: NCH]       channel mask of accepted edges
//   [TS_LSB   +: TW]        timestamp
// Offsets depend on NCH/TW, so they are provided as constant functions that
// the top level evaluates into its own localparams.
package multiclickreg_pkg;

  localparam int TS_LSB = 0;

  function automatic int mask_lsb(input int tw);
    return TS_LSB + tw;
  endfunction

  function automatic int roll_bit(input int nch, input int tw);
    return TS_LSB + tw + nch;
  endfunction

  function automatic int word_w(input int nch, input int tw);
    return 1 + nch + tw;
  endfunction

  // Saturation value of an lw-bit lost-event counter (2^lw - 1).
  function automatic logic [63:0] lost_sat(input int lw);
    return (64'd1 << lw) - 64'd1;
  endfunction

endpackage

// File: rtl/multiclickreg_if.sv
// multiclickreg_if -- detector inputs and host readout bus of multiclickreg.
//
// Signals:
//   channel  (NCH)        synchronized detector levels
//   operate               enables rollover marker words
//   rd                    host pops the head word when valid=1
//   ovf_clr               synchronous clear of overflow / lost_cnt
//   data     (1+NCH+TW)   head word {rollover, mask, timestamp}
//   valid                 head word present
//   overflow              sticky drop flag
//   lost_cnt (LW)         saturating dropped-word count
// Modports: slave = the multiclickreg block, master = detector/host side.
interface multiclickreg_if #(
  parameter int NCH = 4,
  parameter int TW  = 27,
  parameter int LW  = 16
);
  logic [NCH-1:0]    channel;
  logic              operate;
  logic              rd;
  logic              ovf_clr;
  logic [NCH+TW:0]   data;
  logic              valid;
  logic              overflow;
  logic [LW-1:0]     lost_cnt;

  modport slave (
    input  channel, operate, rd, ovf_clr,
    output data, valid, overflow, lost_cnt
  );

  modport master (
    output channel, operate, rd, ovf_clr,
    input  data, valid, overflow, lost_cnt
  );
endinterface

// File: rtl/multiclickreg_tag_fifo.sv
// tag_fifo -- synchronous FIFO with a registered first-word fall-through head.
//
// Ports:
//   clk, clear  clock and asynchronous active-high reset
//   push, din   write request and word; ignored when full unless popping
//   pop         read request; ignored while the head is not valid
//   full        DEPTH words stored
//   empty       no valid head word presented to the reader
//   head        registered head word, meaningful while empty=0
//
// A word written on edge N becomes visible on head after edge N+1. The head
// register is reloaded every cycle from the post-pop read pointer, so it stays
// stable while nothing is popped.
module tag_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic [AW:0]  rptr_nxt;
  logic         head_vld;
  logic         do_pop;
  logic         do_push;

  assign do_pop   = pop & head_vld;
  assign do_push  = push & (~full | do_pop);
  assign rptr_nxt = rptr + {{AW{1'b0}}, do_pop};
  // Pointers carry one extra wrap bit: equal indices with differing wrap
  // bits means every slot is occupied.
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty    = ~head_vld;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      wptr     <= '0;
      rptr     <= '0;
      head_vld <= 1'b0;
      head     <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      rptr <= rptr_nxt;
      // Compare against the pre-edge write pointer: a word written on this
      // edge is not readable until the next one.
      head_vld <= (wptr != rptr_nxt);
      if (wptr != rptr_nxt) head <= mem[rptr_nxt[AW-1:0]];
    end
  end

endmodule

// File: rtl/multiclickreg.sv
// multiclickreg -- multichannel pulse registration and time stamping.
//
// Rising edges on the NCH synchronized channel inputs are stamped with a
// free-running TW-bit timer and packed, together with an optional timer
// rollover marker, into one event word per cycle. Words are queued in a
// DEPTH-word FIFO and drained by the host through valid/rd.
//
// Ports:
//   clk    sole clock
//   clear  asynchronous active-high reset; discards every queued word
//   bus    multiclickreg_if.slave: channel, operate, rd, ovf_clr in;
//          data, valid, overflow, lost_cnt out
//
// Build option: define MULTICLICKREG_HOLDOFF_EN to give every channel a
// holdoff counter that ignores edges for HOLDOFF cycles after an accepted
// edge. Without it every rising edge is registered and HOLDOFF is unused.
module multiclickreg
  import multiclickreg_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int TW      = 27,
  parameter int DEPTH   = 16,
  parameter int HOLDOFF = 3,
  parameter int LW      = 16
) (
  input  logic            clk,
  input  logic            clear,
  multiclickreg_if.slave  bus
);
  localparam int WW       = word_w(NCH, TW);
  localparam int ROLL_BIT = roll_bit(NCH, TW);
  localparam int MASK_LSB = mask_lsb(TW);
  localparam logic [LW-1:0] LOST_MAX = LW'(lost_sat(LW));

  if (NCH < 1 || NCH > 8 || HOLDOFF < 0 || HOLDOFF > 255 ||
      DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
    $error("multiclickreg: parameter out of range");
  end

  logic [TW-1:0]  timer;
  logic [NCH-1:0] prev;
  logic [NCH-1:0] edge_det;
  logic [NCH-1:0] accept;
  logic           mk;
  logic [WW-1:0]  word_p0;
  logic           vld_p0;
  logic [WW-1:0]  word_p1;
  logic           vld_p1;
  logic           full;
  logic           empty;
  logic           pop;
  logic           drop;
  logic [WW-1:0]  head;
  logic           ovf;
  logic [LW-1:0]  lost;

  assign edge_det = bus.channel & ~prev;
  assign mk       = bus.operate & (timer == '0);

`ifdef MULTICLICKREG_HOLDOFF_EN
  localparam logic [7:0] HOLD_INIT = 8'(HOLDOFF);
  logic [7:0] hold [NCH];

  always_comb begin
    accept = '0;
    for (int i = 0; i < NCH; i++) accept[i] = edge_det[i] & (hold[i] == 8'd0);
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < NCH; i++) hold[i] <= 8'd0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (accept[i])           hold[i] <= HOLD_INIT;
        else if (hold[i] != 8'd0) hold[i] <= hold[i] - 8'd1;
      end
    end
  end
`else
  assign accept = edge_det;
`endif

  // ---- p0: word formation from this cycle's edges, marker and timer ----
  always_comb begin
    word_p0                   = '0;
    word_p0[ROLL_BIT]         = mk;
    word_p0[MASK_LSB +: NCH]  = accept;
    word_p0[TS_LSB +: TW]     = timer;
  end
  assign vld_p0 = mk | (|accept);

  // prev resets to ones so a channel already high at release is not an edge.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      timer  <= '0;
      prev   <= '1;
      vld_p1 <= 1'b0;
    end else begin
      timer  <= timer + TW'(1);
      prev   <= bus.channel;
      vld_p1 <= vld_p0;
    end
  end

  always_ff @(posedge clk) begin
    word_p1 <= word_p0;
  end

  // ---- p1: push into the FIFO, or drop and account ----
  assign pop  = bus.rd & ~empty;
  assign drop = vld_p1 & full & ~pop;

  tag_fifo #(
    .W     (WW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clear (clear),
    .push  (vld_p1),
    .din   (word_p1),
    .pop   (bus.rd),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // A drop coinciding with ovf_clr restarts the count at one.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      ovf  <= 1'b0;
      lost <= '0;
    end else if (drop) begin
      ovf  <= 1'b1;
      if (bus.ovf_clr)          lost <= LW'(1);
      else if (lost != LOST_MAX) lost <= lost + LW'(1);
    end else if (bus.ovf_clr) begin
      ovf  <= 1'b0;
      lost <= '0;
    end
  end

  // ---- p2: registered head presented to the host ----
  assign bus.data     = head;
  assign bus.valid    = ~empty;
  assign bus.overflow = ovf;
  assign bus.lost_cnt = lost;

endmodule

// File: tb/tb_multiclickreg.sv
// tb_multiclickreg -- directed self-checking bench for multiclickreg.
// Configuration: NCH=4, TW=8, DEPTH=4, HOLDOFF=3, LW=16.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// After a reset released on a falling edge, the k-th following rising edge
// is called Ek; an input raised right after Ek is stamped with timer value k.
module tb_multiclickreg;
  localparam int NCH = 4;
  localparam int TW  = 8;
  localparam int LW  = 16;
  localparam int WW  = 1 + NCH + TW;

  logic clk;
  logic clear;
  int   n_vec;
  int   n_err;

  multiclickreg_if #(.NCH(NCH), .TW(TW), .LW(LW)) bus ();

  multiclickreg #(
    .NCH(NCH), .TW(TW), .DEPTH(4), .HOLDOFF(3), .LW(LW)
  ) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WW-1:0] mkw(input logic r, input logic [3:0] m,
                                        input logic [7:0] ts);
    return {r, m, ts};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    bus.channel = 4'hF; bus.operate = 1'b0; bus.rd = 1'b0; bus.ovf_clr = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.data !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", bus.data); end
    n_vec++; if (bus.valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
    n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", bus.overflow); end
    n_vec++; if (bus.lost_cnt !== '0) begin n_err++; $display("FAIL reset_lost: got %0d want 0", bus.lost_cnt); end
    @(negedge clk);
    clear = 1'b0;
    tick(6);
    n_vec++; if (bus.valid !== 1'b0) begin n_err++; $display("FAIL reset_high_ch: valid %b want 0", bus.valid); end
    bus.channel = '0;
  endtask

  task automatic test_marker();
    bus.channel = '0; bus.operate = 1'b1;
    do_reset();
    tick(2);
    n_vec++; if (bus.valid !== 1'b0) begin n_err++; $display("FAIL mk_early: valid %b want 0 at E2", bus.valid); end
    tick(1);
    n_vec++; if (bus.valid !== 1'b1) begin n_err++; $display("FAIL mk_valid: valid %b want 1 at E3", bus.valid); end
    n_vec++; if (bus.data !== mkw(1'b1, 4'h0, 8'd0)) begin n_err++; $display("FAIL mk_word: got %h want %h", bus.data, mkw(1'b1, 4'h0, 8'd0)); end
    bus.rd = 1'b1;
    tick(1);
    bus.rd = 1'b0;
    tick(254);
    n_vec++; if (bus.valid !== 1'b0) begin n_err++; $display("FAIL mk_gap: valid %b want 0 at E258", bus.valid); end
    tick(1);
    n_vec++; if (bus.valid !== 1'b1) begin n_err++; $display("FAIL mk2_valid: valid %b want 1 at E259", bus.valid); end
    n_vec++; if (bus.data !== mkw(1'b1, 4'h0, 8'd0)) begin n_err++; $display("FAIL mk2_word: got %h want %h", bus.data, mkw(1'b1, 4'h0, 8'd0)); end
    bus.operate = 1'b0;
  endtask

  task automatic test_edges();
    bus.channel = '0; bus.operate = 1'b0; bus.rd = 1'b0;
    do_reset();
    tick(5);
    bus.channel = 4'b0001;
    tick(2);
    n_vec++; if (bus.valid !== 1'b0) begin n_err++; $display("FAIL edge_latency: valid %b want 0 at E7", bus.valid); end
    tick(1);
    n_vec++; if (bus.valid !== 1'b1) begin n_err++; $display("FAIL edge_valid: valid %b want 1 at E8", bus.valid); end
    n_vec++; if (bus.data !== mkw(1'b0, 4'b0001, 8'd5)) begin n_err++; $display("FAIL edge_ch0: got %h want %h", bus.data, mkw(1'b0, 4'b0001, 8'd5)); end
    bus.rd = 1'b1;
    tick(1);
    bus.rd = 1'b0;
    n_vec++; if (bus.valid !== 1'b0) begin n_err++; $display("FAIL edge_pop: valid %b want 0", bus.valid); end
    bus.channel = 4'b1010;
    tick(3);
    n_vec++; if (bus.data !== mkw(1'b0, 4'b1010, 8'd9) || bus.valid !== 1'b1) begin
      n_err++; $display("FAIL edge_merge: got v=%b %h want v=1 %h", bus.valid, bus.data, mkw(1'b0, 4'b1010, 8'd9));
    end
    bus.rd = 1'b1;
    tick(1);
    bus.rd = 1'b0;
    bus.channel = '0;
  endtask

  task automatic test_holdoff();
    logic [WW-1:0] got [16];
    logic [7:0]    exp_ts [8];
    int            nw;
    int            ne;
    bus.channel = '0; bus.operate = 1'b0;
    do_reset();
    bus.rd = 1'b1;
    nw = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (bus.valid === 1'b1 && nw < 16) begin got[nw] = bus.data; nw++; end
      bus.channel[2] = (k >= 2 && k <= 14 && (k % 2) == 0);
    end
    bus.rd = 1'b0;
`ifdef MULTICLICKREG_HOLDOFF_EN
    ne = 4;
    exp_ts[0] = 8'd2; exp_ts[1] = 8'd6; exp_ts[2] = 8'd10; exp_ts[3] = 8'd14;
`else
    ne = 7;
    for (int i = 0; i < 7; i++) exp_ts[i] = 8'(2 + 2 * i);
`endif
    n_vec++; if (nw != ne) begin n_err++; $display("FAIL hold_count: got %0d words want %0d", nw, ne); end
    for (int i = 0; i < ne && i < nw; i++) begin
      n_vec++;
      if (got[i] !== mkw(1'b0, 4'b0100, exp_ts[i])) begin
        n_err++; $display("FAIL hold_word%0d: got %h want %h", i, got[i], mkw(1'b0, 4'b0100, exp_ts[i]));
      end
    end
  endtask

  // Drains with rd=1 and compares against stamps on channel 0.
  task automatic drain_check(input int ne, input int ts0, input string tag);
    logic [WW-1:0] got [16];
    int            nw;
    nw = 0;
    bus.rd = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.valid === 1'b1 && nw < 16) begin got[nw] = bus.data; nw++; end
      tick(1);
    end
    bus.rd = 1'b0;
    n_vec++; if (nw != ne) begin n_err++; $display("FAIL %s_count: got %0d words want %0d", tag, nw, ne); end
    for (int i = 0; i < ne && i < nw; i++) begin
      n_vec++;
      if (got[i] !== mkw(1'b0, 4'b0001, 8'(ts0 + 4 * i))) begin
        n_err++; $display("FAIL %s_word%0d: got %h want %h", tag, i, got[i], mkw(1'b0, 4'b0001, 8'(ts0 + 4 * i)));
      end
    end
  endtask

  task automatic test_overflow();
    bus.channel = '0; bus.operate = 1'b0; bus.rd = 1'b0; bus.ovf_clr = 1'b0;
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      bus.channel[0] = ((k % 4) == 2) && (k <= 22);
    end
    n_vec++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", bus.overflow); end
    n_vec++; if (bus.lost_cnt !== 16'd2) begin n_err++; $display("FAIL ovf_lost: got %0d want 2", bus.lost_cnt); end
    bus.ovf_clr = 1'b1;
    tick(1);
    bus.ovf_clr = 1'b0;
    n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr_flag: got %b want 0", bus.overflow); end
    n_vec++; if (bus.lost_cnt !== 16'd0) begin n_err++; $display("FAIL ovf_clr_lost: got %0d want 0", bus.lost_cnt); end
    drain_check(4, 2, "ovf_drain");
  endtask

  task automatic test_back_to_back();
    bus.channel = '0; bus.rd = 1'b0;
    do_reset();
    for (int k = 1; k <= 19; k++) begin
      tick(1);
      bus.channel[0] = ((k % 4) == 2) && (k <= 18);
    end
    bus.rd = 1'b1;
    tick(1);
    bus.rd = 1'b0;
    tick(2);
    n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL full_rw_ovf: got %b want 0", bus.overflow); end
    n_vec++; if (bus.lost_cnt !== 16'd0) begin n_err++; $display("FAIL full_rw_lost: got %0d want 0", bus.lost_cnt); end
    drain_check(4, 6, "full_rw");
  endtask

  task automatic test_clr_vs_drop();
    bus.channel = '0; bus.rd = 1'b0; bus.ovf_clr = 1'b0;
    do_reset();
    for (int k = 1; k <= 27; k++) begin
      tick(1);
      bus.channel[0] = ((k % 4) == 2) && (k <= 26);
    end
    n_vec++; if (bus.lost_cnt !== 16'd2) begin n_err++; $display("FAIL cvd_pre: lost %0d want 2", bus.lost_cnt); end
    bus.ovf_clr = 1'b1;
    tick(1);
    bus.ovf_clr = 1'b0;
    n_vec++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL cvd_flag: got %b want 1", bus.overflow); end
    n_vec++; if (bus.lost_cnt !== 16'd1) begin n_err++; $display("FAIL cvd_lost: got %0d want 1", bus.lost_cnt); end
  endtask

  task automatic test_clear();
    bus.channel = '0; bus.rd = 1'b0;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      bus.channel[0] = ((k % 4) == 2) && (k <= 10);
    end
    n_vec++; if (bus.valid !== 1'b1) begin n_err++; $display("FAIL clr_pre: valid %b want 1", bus.valid); end
    bus.channel = 4'hF;
    #1 clear = 1'b1;
    #1;
    n_vec++; if (bus.valid !== 1'b0) begin n_err++; $display("FAIL clr_valid: got %b want 0", bus.valid); end
    n_vec++; if (bus.data !== '0) begin n_err++; $display("FAIL clr_data: got %h want 0", bus.data); end
    @(negedge clk);
    @(negedge clk);
    clear = 1'b0;
    tick(8);
    n_vec++; if (bus.valid !== 1'b0) begin n_err++; $display("FAIL clr_held_high: valid %b want 0", bus.valid); end
    bus.channel = '0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clear = 1'b1;
    test_reset();
    test_marker();
    test_edges();
    test_holdoff();
    test_overflow();
    test_back_to_back();
    test_clr_vs_drop();
    test_clear();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
